// File: rtl/uart_fifo_core.sv
// rtl/uart_fifo_core.sv - parametrised full-duplex UART with TX/RX FIFOs, parity, error flags and loopback
//
// Purpose: serial transmitter and receiver sharing one oversampling tick,
// each fronted by a small circular FIFO towards the processor side.
//
// Ports (uart_fifo_core):
//   i_clock, i_reset      clock, asynchronous active-low reset
//   i_loopback            1: RX listens to the internal TX line, o_tx held at 1
//   i_rx / o_tx           serial pins (i_rx asynchronous, o_tx idles high)
//   i_wr_en, i_wr_data    push into TX FIFO; o_tx_full reports no room
//   i_rd_en, o_rd_data    pop RX FIFO head (fall-through); o_rx_empty
//   o_parity_err, o_frame_err, o_overrun   sticky flags, cleared by i_clr_err
//
// Ports (uart_fifo_core_fifo):
//   s_tdata/s_tvalid/s_tready  write side; s_tvalid writes unconditionally
//   m_tdata/m_tvalid/m_tready  read side; m_tready pops when not empty

module uart_fifo_core_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tvalid,
  output logic          s_tready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;

  // Extra pointer bit: equal pointers mean empty, differing only in the top bit mean full.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign s_tready = !full;
  assign m_tvalid = !empty;
  assign m_tdata  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (s_tvalid) wr_ptr <= wr_ptr + PTR_ONE;
      if (m_tready && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clock) begin
    if (s_tvalid) mem[wr_ptr[AW-1:0]] <= s_tdata;
  end
endmodule

module uart_fifo_core #(
  parameter int NB_DATA    = 8,
  parameter int SB_TICK    = 16,
  parameter int CLK_DIV    = 163,
  parameter int FIFO_AW    = 2,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_loopback,
  input  logic               i_rx,
  output logic               o_tx,
  input  logic               i_wr_en,
  input  logic [NB_DATA-1:0] i_wr_data,
  output logic               o_tx_full,
  input  logic               i_rd_en,
  output logic [NB_DATA-1:0] o_rd_data,
  output logic               o_rx_empty,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_overrun,
  input  logic               i_clr_err
);
  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(SB_TICK);
  localparam int NW = $clog2(NB_DATA);

  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SB_LAST   = SW'(SB_TICK - 1);
  localparam logic [SW-1:0] SB_HALF   = SW'(SB_TICK / 2 - 1);
  localparam logic [NW-1:0] NB_LAST   = NW'(NB_DATA - 1);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // ---------------- tick generator ----------------
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)  tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  // ---------------- TX path ----------------
  logic [NB_DATA-1:0] txf_data;
  logic               txf_valid;
  logic               txf_ready;
  logic               tx_pop;
  logic [2:0]         tx_state;
  logic [SW-1:0]      tx_scnt;
  logic [NW-1:0]      tx_ncnt;
  logic [NB_DATA-1:0] tx_shreg;
  logic               tx_par;
  logic               tx_bit;
  logic               tx_line;

  uart_fifo_core_fifo #(.DW(NB_DATA), .AW(FIFO_AW)) u_tx_fifo (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .s_tdata  (i_wr_data),
    .s_tvalid (i_wr_en && txf_ready),
    .s_tready (txf_ready),
    .m_tdata  (txf_data),
    .m_tvalid (txf_valid),
    .m_tready (tx_pop)
  );

  assign o_tx_full = !txf_ready;

  // Load from idle at once, or straight from the end of a stop bit for gapless frames.
  assign tx_pop = txf_valid &&
                  ((tx_state == ST_IDLE) ||
                   (tx_state == ST_STOP && tick && tx_scnt == SB_LAST));

  always_comb begin
    tx_bit = 1'b1;
    case (tx_state)
      ST_START:  tx_bit = 1'b0;
      ST_DATA:   tx_bit = tx_shreg[0];
      ST_PARITY: tx_bit = tx_par;
      default:   tx_bit = 1'b1;
    endcase
  end

  // tx_line is re-timed on ticks so every bit on the wire spans exactly SB_TICK ticks,
  // independent of the clock phase at which the frame was loaded.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      tx_state <= ST_IDLE;
      tx_scnt  <= '0;
      tx_ncnt  <= '0;
      tx_shreg <= '0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
    end else begin
      if (tick) tx_line <= tx_bit;
      if (tx_pop) begin
        tx_state <= ST_START;
        tx_scnt  <= '0;
        tx_ncnt  <= '0;
        tx_shreg <= txf_data;
        tx_par   <= (^txf_data) ^ PAR_ODD;
      end else if (tick && tx_state != ST_IDLE) begin
        if (tx_scnt == SB_LAST) begin
          tx_scnt <= '0;
          case (tx_state)
            ST_START: tx_state <= ST_DATA;
            ST_DATA: begin
              tx_shreg <= tx_shreg >> 1;
              if (tx_ncnt == NB_LAST) tx_state <= HAS_PAR ? ST_PARITY : ST_STOP;
              else                    tx_ncnt  <= tx_ncnt + NW'(1);
            end
            ST_PARITY: tx_state <= ST_STOP;
            default:   tx_state <= ST_IDLE;
          endcase
        end else begin
          tx_scnt <= tx_scnt + SW'(1);
        end
      end
    end
  end

  assign o_tx = i_loopback ? 1'b1 : tx_line;

  // ---------------- RX path ----------------
  logic               rx_src;
  logic               rx_meta;
  logic               rx_sync;
  logic               rx_prev;
  logic [2:0]         rx_state;
  logic [SW-1:0]      rx_scnt;
  logic [NW-1:0]      rx_ncnt;
  logic [NB_DATA-1:0] rx_shreg;
  logic               rx_par_bad;
  logic [SW-1:0]      rx_target;
  logic               rx_at_sample;
  logic               par_evt;
  logic               stop_evt;
  logic               frame_evt;
  logic               rx_good;
  logic               rxf_ready;
  logic               rxf_valid;
  logic               rx_push;
  logic               overrun_evt;

  assign rx_src = i_loopback ? tx_line : i_rx;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_src;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // START waits half a bit to land mid-start; later states wait a whole bit from there.
  assign rx_target    = (rx_state == ST_START) ? SB_HALF : SB_LAST;
  assign rx_at_sample = tick && (rx_scnt == rx_target);
  assign par_evt      = (rx_state == ST_PARITY) && rx_at_sample &&
                        (rx_sync != ((^rx_shreg) ^ PAR_ODD));
  assign stop_evt     = (rx_state == ST_STOP) && rx_at_sample;
  assign frame_evt    = stop_evt && !rx_sync;
  assign rx_good      = stop_evt && rx_sync && !rx_par_bad;
  // A pop in the same cycle frees the slot the new byte needs.
  assign rx_push      = rx_good && (rxf_ready || i_rd_en);
  assign overrun_evt  = rx_good && !rxf_ready && !i_rd_en;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_state   <= ST_IDLE;
      rx_scnt    <= '0;
      rx_ncnt    <= '0;
      rx_shreg   <= '0;
      rx_par_bad <= 1'b0;
    end else begin
      case (rx_state)
        ST_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= ST_START;
            rx_scnt  <= '0;
          end
        end
        ST_START: begin
          if (rx_at_sample) begin
            rx_scnt    <= '0;
            rx_ncnt    <= '0;
            rx_par_bad <= 1'b0;
            rx_state   <= rx_sync ? ST_IDLE : ST_DATA;
          end else if (tick) begin
            rx_scnt <= rx_scnt + SW'(1);
          end
        end
        ST_DATA: begin
          if (rx_at_sample) begin
            rx_scnt  <= '0;
            rx_shreg <= {rx_sync, rx_shreg[NB_DATA-1:1]};
            if (rx_ncnt == NB_LAST) rx_state <= HAS_PAR ? ST_PARITY : ST_STOP;
            else                    rx_ncnt  <= rx_ncnt + NW'(1);
          end else if (tick) begin
            rx_scnt <= rx_scnt + SW'(1);
          end
        end
        ST_PARITY: begin
          if (rx_at_sample) begin
            rx_scnt    <= '0;
            rx_par_bad <= par_evt;
            rx_state   <= ST_STOP;
          end else if (tick) begin
            rx_scnt <= rx_scnt + SW'(1);
          end
        end
        ST_STOP: begin
          if (rx_at_sample) begin
            rx_scnt  <= '0;
            rx_state <= ST_IDLE;
          end else if (tick) begin
            rx_scnt <= rx_scnt + SW'(1);
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  uart_fifo_core_fifo #(.DW(NB_DATA), .AW(FIFO_AW)) u_rx_fifo (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .s_tdata  (rx_shreg),
    .s_tvalid (rx_push),
    .s_tready (rxf_ready),
    .m_tdata  (o_rd_data),
    .m_tvalid (rxf_valid),
    .m_tready (i_rd_en)
  );

  assign o_rx_empty = !rxf_valid;

  // ---------------- sticky error flags (set beats clear) ----------------
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      if (par_evt)        o_parity_err <= 1'b1;
      else if (i_clr_err) o_parity_err <= 1'b0;
      if (frame_evt)      o_frame_err  <= 1'b1;
      else if (i_clr_err) o_frame_err  <= 1'b0;
      if (overrun_evt)    o_overrun    <= 1'b1;
      else if (i_clr_err) o_overrun    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_fifo_core.sv
// tb/tb_uart_fifo_core.sv - directed self-checking bench for uart_fifo_core

module tb_uart_fifo_core;
  localparam int NB  = 8;
  localparam int BIT = 64;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_loopback = 1'b0;
  logic          i_rx = 1'b1;
  logic          o_tx;
  logic          i_wr_en = 1'b0;
  logic [NB-1:0] i_wr_data = '0;
  logic          o_tx_full;
  logic          i_rd_en = 1'b0;
  logic [NB-1:0] o_rd_data;
  logic          o_rx_empty;
  logic          o_parity_err;
  logic          o_frame_err;
  logic          o_overrun;
  logic          i_clr_err = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  logic       mon_en = 1'b0;
  logic [9:0] mon_f;
  logic [9:0] mon_q[$];

  uart_fifo_core #(
    .NB_DATA(8), .SB_TICK(16), .CLK_DIV(4), .FIFO_AW(2), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_loopback   (i_loopback),
    .i_rx         (i_rx),
    .o_tx         (o_tx),
    .i_wr_en      (i_wr_en),
    .i_wr_data    (i_wr_data),
    .o_tx_full    (o_tx_full),
    .i_rd_en      (i_rd_en),
    .o_rd_data    (o_rd_data),
    .o_rx_empty   (o_rx_empty),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun),
    .i_clr_err    (i_clr_err)
  );

  always #5 i_clock = ~i_clock;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clock);
      #1;
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    i_loopback = 1'b0;
    i_rx = 1'b1;
    i_wr_en = 1'b0;
    i_rd_en = 1'b0;
    i_clr_err = 1'b0;
    step(3);
    i_reset = 1'b1;
    step(2);
  endtask

  task automatic push(input logic [NB-1:0] d);
    i_wr_en = 1'b1;
    i_wr_data = d;
    step(1);
    i_wr_en = 1'b0;
  endtask

  task automatic pop();
    i_rd_en = 1'b1;
    step(1);
    i_rd_en = 1'b0;
  endtask

  task automatic send_rx(input logic [NB-1:0] d, input logic par, input logic stp);
    i_rx = 1'b0;
    step(BIT);
    for (int i = 0; i < NB; i++) begin
      i_rx = d[i];
      step(BIT);
    end
    i_rx = par;
    step(BIT);
    i_rx = stp;
    step(BIT);
    i_rx = 1'b1;
    step(BIT);
  endtask

  // Decodes frames on o_tx into {stop, parity, data}, sampling mid-bit.
  initial begin
    forever begin
      @(posedge i_clock);
      #1;
      if (mon_en && o_tx === 1'b0) begin
        step(31);
        for (int b = 0; b < 10; b++) begin
          step(BIT);
          mon_f[b] = o_tx;
        end
        mon_q.push_back(mon_f);
      end
    end
  end

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({o_tx, o_tx_full, o_rx_empty} !== 3'b101) $display("FAIL reset_pins tx/full/empty got %b want 101", {o_tx, o_tx_full, o_rx_empty});
    else n_pass++;
    n_total++;
    if (o_rd_data !== 8'h00) $display("FAIL reset_rd_data got %h want 00", o_rd_data);
    else n_pass++;
    n_total++;
    if ({o_parity_err, o_frame_err, o_overrun} !== 3'b000) $display("FAIL reset_flags got %b want 000", {o_parity_err, o_frame_err, o_overrun});
    else n_pass++;
    pop();
    n_total++;
    if ({o_rx_empty, o_rd_data} !== {1'b1, 8'h00}) $display("FAIL pop_empty got %b/%h want 1/00", o_rx_empty, o_rd_data);
    else n_pass++;
  endtask

  task automatic test_loopback();
    bit tx_low;
    do_reset();
    i_loopback = 1'b1;
    tx_low = 1'b0;
    push(8'hA5);
    push(8'h3C);
    for (int i = 0; i < 1600; i++) begin
      if (o_tx !== 1'b1) tx_low = 1'b1;
      step(1);
    end
    n_total++;
    if (tx_low !== 1'b0) $display("FAIL loop_tx_idle got low=%b want 0", tx_low);
    else n_pass++;
    n_total++;
    if (o_rd_data !== 8'hA5) $display("FAIL loop_byte0 got %h want a5", o_rd_data);
    else n_pass++;
    pop();
    n_total++;
    if (o_rd_data !== 8'h3C) $display("FAIL loop_byte1 got %h want 3c", o_rd_data);
    else n_pass++;
    pop();
    n_total++;
    if ({o_rx_empty, o_parity_err, o_frame_err, o_overrun} !== 4'b1000) $display("FAIL loop_end empty/flags got %b want 1000", {o_rx_empty, o_parity_err, o_frame_err, o_overrun});
    else n_pass++;
    i_loopback = 1'b0;
  endtask

  task automatic test_tx_waveform();
    int c;
    int bad;
    logic [10:0] exp_bits;
    logic [10:0] obs;
    do_reset();
    exp_bits = {1'b1, 1'b1, 8'h01, 1'b0};
    push(8'h01);
    c = 0;
    while (o_tx === 1'b1 && c < 20) begin
      step(1);
      c++;
    end
    n_total++;
    if (c < 1 || c > 6) $display("FAIL tx_latency got %0d clocks want 1..6", c);
    else n_pass++;
    for (int k = 0; k < 11; k++) begin
      bad = 0;
      obs[k] = o_tx;
      for (int s = 0; s < BIT; s++) begin
        if (o_tx !== exp_bits[k]) bad++;
        step(1);
      end
      n_total++;
      if (bad !== 0) $display("FAIL tx_bit%0d got %0d wrong samples (first=%b) want 0 (level %b)", k, bad, obs[k], exp_bits[k]);
      else n_pass++;
    end
    step(40);
    n_total++;
    if (o_tx !== 1'b1) $display("FAIL tx_idle_after got %b want 1", o_tx);
    else n_pass++;
  endtask

  task automatic test_rx_errors();
    do_reset();
    send_rx(8'h55, 1'b1, 1'b1);
    n_total++;
    if ({o_parity_err, o_frame_err, o_rx_empty} !== 3'b101) $display("FAIL rx_parity perr/ferr/empty got %b want 101", {o_parity_err, o_frame_err, o_rx_empty});
    else n_pass++;
    send_rx(8'h55, 1'b0, 1'b0);
    n_total++;
    if ({o_parity_err, o_frame_err, o_rx_empty} !== 3'b111) $display("FAIL rx_frame perr/ferr/empty got %b want 111", {o_parity_err, o_frame_err, o_rx_empty});
    else n_pass++;
    i_clr_err = 1'b1;
    step(1);
    i_clr_err = 1'b0;
    n_total++;
    if ({o_parity_err, o_frame_err, o_overrun} !== 3'b000) $display("FAIL rx_clear got %b want 000", {o_parity_err, o_frame_err, o_overrun});
    else n_pass++;
    send_rx(8'h96, 1'b0, 1'b1);
    n_total++;
    if ({o_rx_empty, o_rd_data, o_parity_err} !== {1'b0, 8'h96, 1'b0}) $display("FAIL rx_good got empty=%b data=%h perr=%b want 0/96/0", o_rx_empty, o_rd_data, o_parity_err);
    else n_pass++;
  endtask

  task automatic test_overrun();
    logic [NB-1:0] exp_b;
    do_reset();
    i_loopback = 1'b1;
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    n_total++;
    if (o_tx_full !== 1'b1) $display("FAIL ovr_fifth_accepted tx_full got %b want 1", o_tx_full);
    else n_pass++;
    step(5 * 704 + 300);
    n_total++;
    if ({o_overrun, o_parity_err, o_frame_err} !== 3'b100) $display("FAIL ovr_flags got %b want 100", {o_overrun, o_parity_err, o_frame_err});
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'h10 + 8'(i);
      n_total++;
      if (o_rd_data !== exp_b || o_rx_empty !== 1'b0) $display("FAIL ovr_byte%0d got %h empty=%b want %h", i, o_rd_data, o_rx_empty, exp_b);
      else n_pass++;
      pop();
    end
    n_total++;
    if (o_rx_empty !== 1'b1) $display("FAIL ovr_drained empty got %b want 1", o_rx_empty);
    else n_pass++;
    i_loopback = 1'b0;
  endtask

  task automatic test_tx_full();
    logic [NB-1:0] d;
    logic [9:0]    exp_f;
    do_reset();
    mon_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
    n_total++;
    if (o_tx_full !== 1'b0) $display("FAIL full_after4 got %b want 0", o_tx_full);
    else n_pass++;
    push(8'h24);
    n_total++;
    if (o_tx_full !== 1'b1) $display("FAIL full_after5 got %b want 1", o_tx_full);
    else n_pass++;
    push(8'h25);
    n_total++;
    if (o_tx_full !== 1'b1) $display("FAIL full_after6 got %b want 1", o_tx_full);
    else n_pass++;
    step(5 * 704 + 900);
    mon_en = 1'b0;
    n_total++;
    if (mon_q.size() !== 5) $display("FAIL full_frames got %0d want 5", mon_q.size());
    else n_pass++;
    for (int i = 0; i < 5 && i < mon_q.size(); i++) begin
      d = 8'h20 + 8'(i);
      exp_f = {1'b1, ^d, d};
      n_total++;
      if (mon_q[i] !== exp_f) $display("FAIL full_frame%0d got %b want %b", i, mon_q[i], exp_f);
      else n_pass++;
    end
  endtask

  task automatic test_glitch_and_reset();
    bit tx_low;
    do_reset();
    i_rx = 1'b0;
    step(20);
    i_rx = 1'b1;
    step(200);
    n_total++;
    if ({o_rx_empty, o_parity_err, o_frame_err, o_overrun} !== 4'b1000) $display("FAIL glitch empty/flags got %b want 1000", {o_rx_empty, o_parity_err, o_frame_err, o_overrun});
    else n_pass++;
    send_rx(8'h55, 1'b1, 1'b1);
    push(8'h00);
    push(8'h00);
    push(8'h00);
    step(100);
    n_total++;
    if ({o_tx, o_parity_err} !== 2'b01) $display("FAIL pre_reset tx/perr got %b want 01", {o_tx, o_parity_err});
    else n_pass++;
    i_reset = 1'b0;
    #1;
    n_total++;
    if ({o_tx, o_tx_full, o_rx_empty, o_parity_err, o_frame_err, o_overrun} !== 6'b101000) $display("FAIL mid_reset got %b want 101000", {o_tx, o_tx_full, o_rx_empty, o_parity_err, o_frame_err, o_overrun});
    else n_pass++;
    step(2);
    i_reset = 1'b1;
    tx_low = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (o_tx !== 1'b1) tx_low = 1'b1;
      step(1);
    end
    n_total++;
    if (tx_low !== 1'b0) $display("FAIL post_reset_tx_quiet got low=%b want 0", tx_low);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_tx_waveform();
    test_rx_errors();
    test_overrun();
    test_tx_full();
    test_glitch_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_fifo_core.md
# uart_fifo_core

Parametrised full-duplex UART with built-in baud tick generator, TX and RX FIFOs, optional parity, error detection and an internal loopback mode. It replaces the fixed 8-bit rx/tx/baud-generator trio and sits between the processor-side byte interface and the serial pins.

## Interface
- NB_DATA, 8: data bits per frame, legal range 5–8.
- SB_TICK, 16: oversampling ticks per bit, must be even and ≥ 8.
- CLK_DIV, 163: clocks per oversampling tick, ≥ 2.
- FIFO_AW, 2: FIFO address width; each FIFO holds 2^FIFO_AW entries.
- PARITY_EN, 1: 1 inserts and checks one parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity. Ignored when PARITY_EN = 0.
- i_clock  in  1  single clock.
- i_reset  in  1  reset, asynchronous, active-low.
- i_loopback  in  1  1 routes the internal TX line to the RX input and holds o_tx at 1.
- i_rx  in  1  serial input, asynchronous to i_clock.
- o_tx  out  1  serial output, idles at 1.
- i_wr_en  in  1  pushes i_wr_data into the TX FIFO.
- i_wr_data  in  NB_DATA  byte to transmit.
- o_tx_full  out  1  TX FIFO full.
- i_rd_en  in  1  pops the RX FIFO head.
- o_rd_data  out  NB_DATA  RX FIFO head, first-word fall-through.
- o_rx_empty  out  1  RX FIFO empty.
- o_parity_err, o_frame_err, o_overrun  out  1 each  sticky error flags.
- i_clr_err  in  1  clears all three error flags.

## Operation
- **Tick generator**
  - Counter runs 0..CLK_DIV-1 and wraps.
  - The one-cycle tick fires when the count equals CLK_DIV-1.
  - Free-running; shared by RX and TX.
- **Frame format**
  - 1 start bit (0), then NB_DATA data bits LSB first, then an optional parity bit, then 1 stop bit (1).
  - Parity bit = XOR of the data bits, XOR PARITY_ODD.
- **TX FSM: IDLE → START → DATA → PARITY → STOP → IDLE**
  - PARITY is skipped when PARITY_EN = 0.
  - In IDLE with the FIFO not empty: pop the head into the shift register and enter START. The counters reset on entry.
  - Each state holds its bit for SB_TICK ticks.
  - After STOP, if the FIFO is not empty, go directly to START (back-to-back frames, no idle gap).
- **RX input path**
  - The RX source is selected by i_loopback: i_rx or the internal TX line.
  - The source passes through a 2-flop synchroniser.
- **RX FSM: IDLE → START → DATA → PARITY → STOP → IDLE**
  - IDLE → START on a synchronised 1→0 edge.
  - START counts SB_TICK/2 ticks, then samples. If the sample is 1 (glitch), return to IDLE; otherwise enter DATA.
  - DATA, PARITY and STOP each sample once every SB_TICK ticks.
  - Stop sample = 0: set o_frame_err.
  - Parity mismatch: set o_parity_err.
  - A frame with any error is discarded and not written.
  - A good frame is written to the RX FIFO. If the FIFO is full and i_rd_en is not asserted in the same cycle, the byte is dropped and o_overrun is set.
  - After STOP, return to IDLE. A new start edge is detected from mid-stop onward.
- **FIFOs**
  - Circular buffers with one extra pointer bit to tell full from empty.
  - i_wr_en while o_tx_full is ignored, with no error.
  - i_rd_en while o_rx_empty is ignored.
  - RX FIFO full with a simultaneous pop and RX write: both succeed and the count is unchanged.
  - o_rd_data is 0 while empty.
- **Error flags**
  - Set by events; cleared by i_clr_err.
  - If a set event and i_clr_err occur in the same cycle, set wins.
- **i_loopback**
  - Sampled every cycle.
  - Change it only while both FSMs are idle. A mid-frame change may corrupt frames; only the error flags report this.

## Timing
- **Reset (async assert, synchronous-clock deassert)**
  - Outputs: o_tx = 1, o_tx_full = 0, o_rx_empty = 1, o_rd_data = 0, all error flags 0.
  - Internal state: FSMs IDLE, tick counter 0, FIFO pointers 0.
  - Reset mid-frame aborts the frame immediately and drives o_tx to 1.
- **Bit and frame length**
  - One bit = SB_TICK × CLK_DIV clocks.
  - One frame = (2 + NB_DATA + PARITY_EN) × SB_TICK × CLK_DIV clocks.
- **TX latency:** i_wr_en at edge n with TX idle and FIFO empty: o_tx falls at the first tick at or after edge n+2, so within CLK_DIV+2 clocks.
- **RX latency:** o_rx_empty deasserts 1 clock after the stop-bit sample tick, which is mid-stop-bit.
- **FIFO flags:** o_tx_full and o_rx_empty are registered and update the cycle after the push or pop.
- **Error flags:** assert 1 clock after the offending sample tick.

## Test plan
All scenarios use CLK_DIV=4, SB_TICK=16, NB_DATA=8, PARITY_EN=1, PARITY_ODD=0, FIFO_AW=2, so one bit = 64 clocks and one frame = 704 clocks.

- **Loopback:** i_loopback=1; write 0xA5, 0x3C. Response: after about 1408 clocks the RX FIFO reads 0xA5 then 0x3C, o_tx stays 1 throughout, and no error flags are set.
- **TX waveform:** write 0x01. Response: o_tx shows start 0, data 1,0,0,0,0,0,0,0, parity 1, stop 1; each bit exactly 64 clocks.
- **RX errors:**
  - Drive i_rx with 0x55 and wrong parity 1. Response: o_parity_err=1, FIFO stays empty.
  - Drive a stop bit of 0. Response: o_frame_err=1.
  - Pulse i_clr_err. Response: both flags clear.
- **Overrun:** loopback; write 5 bytes 0x10..0x14 with no reads. Response: the RX FIFO holds 0x10..0x13, o_overrun=1, and the write of 0x14 into the TX FIFO is accepted because the TX FIFO drains.
- **TX FIFO full:** with the TX FSM busy, write 6 bytes back-to-back. Response: o_tx_full=1 after the 5th write (1 in the shift register + 4 in the FIFO), the 6th write is ignored, and exactly 5 frames are transmitted.
- **Glitch and reset:** a 20-clock low pulse on i_rx gives no start, FIFO empty and no flags. Asserting i_reset mid-frame gives o_tx = 1 immediately and all flags and FIFOs cleared.
